// File: rtl/game_pkg.sv
// game_pkg
// Shared game constants and types used by the player bullet pool and by the
// enemy hit-detection stage.
//   BULLET_COUNT : number of player bullet slots
//   SCREEN_W/H   : visible playfield size in pixels
//   SPRITE_SIZE  : edge length of player/enemy sprites in pixels
//   slot_t       : one bullet slot (position + in-use flag)
//   cd_state_t   : fire cooldown FSM states
package game_pkg;

  localparam int BULLET_COUNT = 8;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SPRITE_SIZE  = 32;

  localparam int COORD_W = 10;  // screen coordinates, wrap mod 1024
  localparam int CD_W    = 8;   // cooldown counter width

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
  } slot_t;

  typedef enum logic {
    CD_READY = 1'b0,
    CD_COOL  = 1'b1
  } cd_state_t;

  // Number of set bits in an 8-bit vector (0..8 fits in 4 bits).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/priority_free_slot.sv
// priority_free_slot
// Purely combinational lowest-index picker over a free-slot mask.
//   free_mask : bit i set when slot i can be allocated
//   free_idx  : lowest i with free_mask[i] set (0 when none)
//   any_free  : at least one bit of free_mask is set
module priority_free_slot #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     free_mask,
  output logic [IDX_W-1:0] free_idx,
  output logic             any_free
);

  // Scan from the top down so the last hit (the lowest index) wins.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_bullet_pool.sv
// player_bullet_pool
// Owns the player's shot pool: spawns bullets at the player on accepted fire
// requests, moves active bullets up once per frame, and retires them at the
// top edge or when hit detection flags them.
//   clk25          : pixel clock
//   reset          : synchronous, active-high
//   frame_tick     : one-cycle pulse per video frame
//   fire           : debounced fire button level
//   player_x/y     : player sprite top-left corner
//   bullet_hit     : per-slot kill flags from hit detection (one cycle)
//   bullet_xN/yN   : registered slot positions
//   bullet_activeN : registered slot in-use flags
//   bullet_count   : registered number of active slots
//   fire_dropped   : one-cycle pulse when an accepted shot found the pool full
module player_bullet_pool
  import game_pkg::*;
#(
  parameter int BULLET_COUNT  = game_pkg::BULLET_COUNT,
  parameter int BULLET_SPEED  = 4,
  parameter int SPAWN_X_OFS   = 14,
  parameter int FIRE_COOLDOWN = 8
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic [0:7] bullet_hit,
  output logic [9:0] bullet_x0,
  output logic [9:0] bullet_x1,
  output logic [9:0] bullet_x2,
  output logic [9:0] bullet_x3,
  output logic [9:0] bullet_x4,
  output logic [9:0] bullet_x5,
  output logic [9:0] bullet_x6,
  output logic [9:0] bullet_x7,
  output logic [9:0] bullet_y0,
  output logic [9:0] bullet_y1,
  output logic [9:0] bullet_y2,
  output logic [9:0] bullet_y3,
  output logic [9:0] bullet_y4,
  output logic [9:0] bullet_y5,
  output logic [9:0] bullet_y6,
  output logic [9:0] bullet_y7,
  output logic       bullet_active0,
  output logic       bullet_active1,
  output logic       bullet_active2,
  output logic       bullet_active3,
  output logic       bullet_active4,
  output logic       bullet_active5,
  output logic       bullet_active6,
  output logic       bullet_active7,
  output logic [3:0] bullet_count,
  output logic       fire_dropped
);

  localparam int IDX_W = $clog2(BULLET_COUNT);
  localparam logic [COORD_W-1:0] SPEED_V   = COORD_W'(BULLET_SPEED);
  localparam logic [COORD_W-1:0] SPAWN_OFS = COORD_W'(SPAWN_X_OFS);
  localparam logic [CD_W-1:0]    COOL_LOAD = CD_W'(FIRE_COOLDOWN);

  slot_t slot_reg  [BULLET_COUNT];
  slot_t slot_next [BULLET_COUNT];

  logic [BULLET_COUNT-1:0] active_vec;
  logic [BULLET_COUNT-1:0] active_next_vec;

  logic [3:0] count_reg;
  logic [3:0] count_next;
  logic       fire_dropped_reg;
  logic       fire_dropped_next;

  cd_state_t       cd_state_reg;
  cd_state_t       cd_state_next;
  logic [CD_W-1:0] cd_cnt_reg;
  logic [CD_W-1:0] cd_cnt_next;

  logic             shot_accept;
  logic [IDX_W-1:0] free_idx;
  logic             any_free;

  generate
    for (genvar gi = 0; gi < BULLET_COUNT; gi++) begin : g_active
      assign active_vec[gi]      = slot_reg[gi].active;
      assign active_next_vec[gi] = slot_next[gi].active;
    end
  endgenerate

  // Allocation looks only at registered state, so a slot being hit this
  // cycle is still seen as busy and cannot be reused until next cycle.
  priority_free_slot #(
    .N     (BULLET_COUNT),
    .IDX_W (IDX_W)
  ) u_free_slot (
    .free_mask (~active_vec),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  assign shot_accept = (cd_state_reg == CD_READY) && fire;

  // Cooldown FSM: a shot is consumed even when the pool is full.
  always_comb begin
    cd_state_next = cd_state_reg;
    cd_cnt_next   = cd_cnt_reg;
    case (cd_state_reg)
      CD_READY: begin
        if (fire) begin
          cd_cnt_next   = COOL_LOAD;
          cd_state_next = CD_COOL;
        end
      end
      CD_COOL: begin
        if (cd_cnt_reg == '0) begin
          cd_state_next = CD_READY;
        end else if (frame_tick) begin
          cd_cnt_next = cd_cnt_reg - 1'b1;
          if (cd_cnt_reg == CD_W'(1)) begin
            cd_state_next = CD_READY;
          end
        end
      end
      default: begin
        cd_state_next = CD_READY;
        cd_cnt_next   = '0;
      end
    endcase
  end

  // Per-slot update, priority hit > spawn > motion. A hit on an idle slot
  // is ignored so it does not block a spawn into that slot.
  always_comb begin
    slot_next = slot_reg;
    for (int j = 0; j < BULLET_COUNT; j++) begin
      if (bullet_hit[j] && slot_reg[j].active) begin
        slot_next[j].active = 1'b0;
      end else if (shot_accept && any_free && (int'(free_idx) == j)) begin
        slot_next[j].x      = player_x + SPAWN_OFS;
        slot_next[j].y      = player_y;
        slot_next[j].active = 1'b1;
      end else if (frame_tick && slot_reg[j].active) begin
        // Retire instead of wrapping below the top edge; y keeps its value.
        if (slot_reg[j].y >= SPEED_V) begin
          slot_next[j].y = slot_reg[j].y - SPEED_V;
        end else begin
          slot_next[j].active = 1'b0;
        end
      end
    end
  end

  assign count_next        = popcount8(8'(active_next_vec));
  assign fire_dropped_next = shot_accept && !any_free;

  always_ff @(posedge clk25) begin
    if (reset) begin
      for (int j = 0; j < BULLET_COUNT; j++) begin
        slot_reg[j] <= '0;
      end
      count_reg        <= '0;
      fire_dropped_reg <= 1'b0;
      cd_state_reg     <= CD_READY;
      cd_cnt_reg       <= '0;
    end else begin
      for (int j = 0; j < BULLET_COUNT; j++) begin
        slot_reg[j] <= slot_next[j];
      end
      count_reg        <= count_next;
      fire_dropped_reg <= fire_dropped_next;
      cd_state_reg     <= cd_state_next;
      cd_cnt_reg       <= cd_cnt_next;
    end
  end

  assign bullet_x0 = slot_reg[0].x;
  assign bullet_x1 = slot_reg[1].x;
  assign bullet_x2 = slot_reg[2].x;
  assign bullet_x3 = slot_reg[3].x;
  assign bullet_x4 = slot_reg[4].x;
  assign bullet_x5 = slot_reg[5].x;
  assign bullet_x6 = slot_reg[6].x;
  assign bullet_x7 = slot_reg[7].x;

  assign bullet_y0 = slot_reg[0].y;
  assign bullet_y1 = slot_reg[1].y;
  assign bullet_y2 = slot_reg[2].y;
  assign bullet_y3 = slot_reg[3].y;
  assign bullet_y4 = slot_reg[4].y;
  assign bullet_y5 = slot_reg[5].y;
  assign bullet_y6 = slot_reg[6].y;
  assign bullet_y7 = slot_reg[7].y;

  assign bullet_active0 = slot_reg[0].active;
  assign bullet_active1 = slot_reg[1].active;
  assign bullet_active2 = slot_reg[2].active;
  assign bullet_active3 = slot_reg[3].active;
  assign bullet_active4 = slot_reg[4].active;
  assign bullet_active5 = slot_reg[5].active;
  assign bullet_active6 = slot_reg[6].active;
  assign bullet_active7 = slot_reg[7].active;

  assign bullet_count = count_reg;
  assign fire_dropped = fire_dropped_reg;

endmodule
